pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Next-PC controller for the single-cycle RISC-V core. Drives `pc_next` of the program counter register every cycle, selecting among sequential, branch, jump, trap-vector and trap-return addresses. Owns boot hold-off, stall, halt/resume and trap sequencing. Sits between the control/ALU/branch logic and the program counter; the program counter's registered `pc_current` feeds back in.

## Interface
- `RESET_VECTOR`, 32'h0000_0000: first fetch address after boot.
- `TRAP_VECTOR`, 32'h0000_0100: handler address for traps and misaligned targets.
- `BOOT_WAIT`, 4: cycles held in BOOT after reset release (1..15).

- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset; one clock domain.
- `pc_current`  in  32  registered PC from the program counter.
- `stall`  in  1  hold PC this cycle.
- `branch_taken`  in  1  conditional branch resolved taken.
- `branch_target`  in  32  branch destination.
- `jump`  in  1  JAL/JALR this cycle.
- `jump_target`  in  32  jump destination.
- `trap_req`  in  1  ECALL/illegal-instruction trap request.
- `mret`  in  1  return from trap.
- `halt_req`  in  1  enter HALT.
- `resume`  in  1  leave HALT.
- `pc_next`  out  32  next PC to the program counter (combinational).
- `fetch_valid`  out  1  instruction at `pc_current` is to be executed and retired.
- `epc`  out  32  saved exception PC (registered).
- `misaligned`  out  1  sticky: a taken target had bits [1:0] ≠ 0 (registered).
- `seq_state`  out  2  encoded state: BOOT=0, RUN=1, TRAP=2, HALT=3.

## Operation
- States: BOOT, RUN, TRAP, HALT. Reset → BOOT, boot counter 0, `epc` 0, `misaligned` 0.
- BOOT: `pc_next` = RESET_VECTOR, `fetch_valid` 0; counter increments; at counter = BOOT_WAIT−1 → RUN. All request inputs ignored.
- RUN, `fetch_valid` 1; priority per cycle, highest first:
  1. `trap_req`: `pc_next` = TRAP_VECTOR, `epc` ← `pc_current`, → TRAP.
  2. `mret`: `pc_next` = `epc`, stay RUN.
  3. `halt_req`: `pc_next` = `pc_current`, → HALT.
  4. `stall`: `pc_next` = `pc_current`.
  5. `jump`: `pc_next` = `jump_target` with bit 0 cleared.
  6. `branch_taken`: `pc_next` = `branch_target`.
  7. Otherwise: `pc_next` = `pc_current` + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Misaligned target: for rule 5 (after bit-0 clear) or rule 6, a target with bit 1 set → treated as trap: `pc_next` = TRAP_VECTOR, `epc` ← `pc_current`, `misaligned` ← 1, → TRAP.
- TRAP: one-cycle bubble; `fetch_valid` 0, `pc_next` = `pc_current` (= TRAP_VECTOR); inputs ignored; → RUN.
- HALT: `fetch_valid` 0, `pc_next` = `pc_current`; `resume` → RUN next cycle; all other inputs ignored.
- `misaligned` clears only on reset.

## Timing
- `pc_next` is combinational from state, registers and inputs; the new PC is visible on `pc_current` one edge later.
- `epc`, `misaligned`, state and counter update on the same edge that loads `pc_next`.
- Reset is sampled on `clk`. While `reset` = 1: `pc_next` = RESET_VECTOR, `fetch_valid` 0, `seq_state` 0. Reset asserted mid-TRAP or mid-HALT returns to BOOT on the next edge with the counter restarted.
- First `fetch_valid` = 1 occurs BOOT_WAIT cycles after the first edge with `reset` = 0.
- Simultaneous events follow the RUN priority list. `trap_req` + `mret` in the same cycle → trap, and `epc` is overwritten. `stall` + `jump` → stall, and the jump is lost; the upstream stage re-presents it.

## Structure
- Shared package `rv_pkg`: state enum, the RUN select encoding (SEL_SEQ/BR/JMP/TRAP/EPC/HOLD) and the `PC_INCR` = 4 constant.
- One natural sub-module: `pc_next_mux`, a combinational selector from the select code to a 32-bit address. The FSM, counter and `epc` stay in `pc_sequencer`.

## Test plan
- Boot: reset held for 3 cycles then released, BOOT_WAIT = 4 → `pc_next` = 0 throughout; `fetch_valid` rises on the 4th cycle after release; next PCs 0, 4, 8.
- Branch/jump: `pc_current` = 0x20 with `branch_taken`, target 0x80 → next PC 0x80. `jump`, target 0x101 → 0x100. `stall` + `jump` → 0x20 held.
- Trap/return: `trap_req` at 0x44 → PC 0x100, `epc` = 0x44, TRAP for one cycle with `fetch_valid` 0; later `mret` → PC 0x44.
- Misaligned: `branch_taken`, target 0x1002 at PC 0x30 → PC 0x100, `epc` = 0x30, `misaligned` = 1 and stays 1 until reset.
- Halt: `halt_req` at 0x10 → PC stays 0x10 for 5 cycles, `fetch_valid` 0, and `trap_req` during this time is ignored; `resume` → RUN, next PC 0x14.
- Wrap and mid-op reset: PC 0xFFFF_FFFC in RUN → next PC 0. `reset` asserted during HALT → BOOT next edge, `epc` 0, `misaligned` 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared types and constants for the next-PC sequencing logic.
package rv_pkg;

  // Sequencer state, encoded as seen on the seq_state output.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2,
    ST_HALT = 2'd3
  } seq_state_t;

  // Next-PC source select. SEL_RST drives the reset vector (boot and reset).
  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_JMP  = 3'd2,
    SEL_TRAP = 3'd3,
    SEL_EPC  = 3'd4,
    SEL_HOLD = 3'd5,
    SEL_RST  = 3'd6
  } pc_sel_t;

  localparam logic [31:0] PC_INCR = 32'd4;

  // A control-transfer target must be word aligned; bit 1 set means it is not.
  function automatic logic target_misaligned(input logic [31:0] addr);
    return addr[1];
  endfunction

endpackage

// File: rtl/pc_sequencer_pc_next_mux.sv
// Combinational next-PC selector: maps a select code to a 32-bit address.
module pc_next_mux
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  pc_sel_t     sel,
  input  logic [31:0] pc_current,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] epc,
  output logic [31:0] pc_next
);

  // Address selection; the sequential case wraps naturally at 2^32.
  always_comb begin
    pc_next = pc_current;
    case (sel)
      SEL_SEQ:  pc_next = pc_current + PC_INCR;
      SEL_BR:   pc_next = branch_target;
      SEL_JMP:  pc_next = jump_target;
      SEL_TRAP: pc_next = TRAP_VECTOR;
      SEL_EPC:  pc_next = epc;
      SEL_HOLD: pc_next = pc_current;
      SEL_RST:  pc_next = RESET_VECTOR;
      default:  pc_next = RESET_VECTOR;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: boot hold-off, run priority, trap/return, halt/resume.
module pc_sequencer
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          BOOT_WAIT    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_current,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        trap_req,
  input  logic        mret,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc_next,
  output logic        fetch_valid,
  output logic [31:0] epc,
  output logic        misaligned,
  output logic [1:0]  seq_state
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_WAIT - 1);

  seq_state_t  state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] epc_reg, epc_next;
  logic        mis_reg, mis_next;
  pc_sel_t     sel;
  logic [31:0] jump_clean;

  // JAL/JALR targets always have bit 0 cleared before use.
  assign jump_clean = {jump_target[31:1], 1'b0};

  // State, boot counter, saved PC and sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_BOOT;
      cnt_reg   <= 4'd0;
      epc_reg   <= 32'd0;
      mis_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      epc_reg   <= epc_next;
      mis_reg   <= mis_next;
    end
  end

  // Next-state and select decode; RUN requests are taken in priority order.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    epc_next    = epc_reg;
    mis_next    = mis_reg;
    sel         = SEL_HOLD;
    fetch_valid = 1'b0;
    case (state_reg)
      ST_BOOT: begin
        sel = SEL_RST;
        if (cnt_reg == BOOT_LAST) begin
          state_next = ST_RUN;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      ST_RUN: begin
        fetch_valid = 1'b1;
        if (trap_req) begin
          sel        = SEL_TRAP;
          epc_next   = pc_current;
          state_next = ST_TRAP;
        end else if (mret) begin
          sel = SEL_EPC;
        end else if (halt_req) begin
          sel        = SEL_HOLD;
          state_next = ST_HALT;
        end else if (stall) begin
          sel = SEL_HOLD;
        end else if (jump) begin
          if (target_misaligned(jump_clean)) begin
            sel        = SEL_TRAP;
            epc_next   = pc_current;
            mis_next   = 1'b1;
            state_next = ST_TRAP;
          end else begin
            sel = SEL_JMP;
          end
        end else if (branch_taken) begin
          if (target_misaligned(branch_target)) begin
            sel        = SEL_TRAP;
            epc_next   = pc_current;
            mis_next   = 1'b1;
            state_next = ST_TRAP;
          end else begin
            sel = SEL_BR;
          end
        end else begin
          sel = SEL_SEQ;
        end
      end
      ST_TRAP: begin
        sel        = SEL_HOLD;
        state_next = ST_RUN;
      end
      ST_HALT: begin
        sel = SEL_HOLD;
        if (resume) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        sel        = SEL_RST;
        state_next = ST_BOOT;
      end
    endcase
    // While reset is held the core sees the reset vector and no valid fetch.
    if (reset) begin
      sel         = SEL_RST;
      fetch_valid = 1'b0;
    end
  end

  pc_next_mux #(
    .RESET_VECTOR(RESET_VECTOR),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_mux (
    .sel          (sel),
    .pc_current   (pc_current),
    .branch_target(branch_target),
    .jump_target  (jump_clean),
    .epc          (epc_reg),
    .pc_next      (pc_next)
  );

  assign epc        = epc_reg;
  assign misaligned = mis_reg;
  assign seq_state  = reset ? ST_BOOT : state_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expectations, monitor checks.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_current = 32'd0;
  logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic        trap_req = 1'b0, mret = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic [31:0] branch_target = 32'd0, jump_target = 32'd0;
  logic [31:0] pc_next, epc;
  logic        fetch_valid, misaligned;
  logic [1:0]  seq_state;

  localparam logic [7:0] F_RST = 8'h80, F_STALL = 8'h40, F_BR = 8'h20, F_JMP = 8'h10;
  localparam logic [7:0] F_TRAP = 8'h08, F_MRET = 8'h04, F_HALT = 8'h02, F_RES = 8'h01;
  localparam logic [1:0] B = 2'd0, R = 2'd1, T = 2'd2, H = 2'd3;

  typedef struct {
    int          id;
    logic [31:0] pcn;
    logic        fv;
    logic [1:0]  st;
    logic [31:0] epc;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   step_id = 0;
  bit   stim_done = 1'b0;

  pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .pc_current   (pc_current),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .trap_req     (trap_req),
    .mret         (mret),
    .halt_req     (halt_req),
    .resume       (resume),
    .pc_next      (pc_next),
    .fetch_valid  (fetch_valid),
    .epc          (epc),
    .misaligned   (misaligned),
    .seq_state    (seq_state)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus: drive just after the rising edge, queue expectation.
  task automatic step(input logic [7:0] f, input logic [31:0] pc, input logic [31:0] bt,
                      input logic [31:0] jt, input logic [31:0] e_pcn, input logic e_fv,
                      input logic [1:0] e_st, input logic [31:0] e_epc, input logic e_mis);
    exp_t e;
    @(posedge clk);
    #1;
    reset = f[7]; stall = f[6]; branch_taken = f[5]; jump = f[4];
    trap_req = f[3]; mret = f[2]; halt_req = f[1]; resume = f[0];
    pc_current = pc; branch_target = bt; jump_target = jt;
    e.id = step_id; e.pcn = e_pcn; e.fv = e_fv; e.st = e_st; e.epc = e_epc; e.mis = e_mis;
    exp_q.push_back(e);
    step_id++;
  endtask

  task automatic cmp32(input int id, input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL step%0d %s got=%h want=%h", id, name, got, want);
    end
  endtask

  // Monitor: compare DUT outputs on the falling edge against the queued entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("step %0d pc_next=%h fv=%b st=%0d epc=%h mis=%b",
                 e.id, pc_next, fetch_valid, seq_state, epc, misaligned);
        cmp32(e.id, "pc_next", pc_next, e.pcn);
        cmp32(e.id, "fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
        cmp32(e.id, "seq_state", {30'd0, seq_state}, {30'd0, e.st});
        cmp32(e.id, "epc", epc, e.epc);
        cmp32(e.id, "misaligned", {31'd0, misaligned}, {31'd0, e.mis});
      end
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    // Reset held 3 cycles.
    for (int i = 0; i < 3; i++) step(F_RST, 32'h0, 0, 0, 32'h0, 0, B, 32'h0, 0);
    // Boot hold-off: four BOOT cycles, inputs ignored.
    step(8'h0,   32'h0, 0, 0, 32'h0, 0, B, 32'h0, 0);
    step(F_TRAP, 32'h0, 0, 0, 32'h0, 0, B, 32'h0, 0);
    step(F_HALT, 32'h0, 0, 0, 32'h0, 0, B, 32'h0, 0);
    step(8'h0,   32'h0, 0, 0, 32'h0, 0, B, 32'h0, 0);
    // Sequential run.
    step(8'h0, 32'h0, 0, 0, 32'h4, 1, R, 32'h0, 0);
    step(8'h0, 32'h4, 0, 0, 32'h8, 1, R, 32'h0, 0);
    step(8'h0, 32'h8, 0, 0, 32'hC, 1, R, 32'h0, 0);
    // Branch, jump (bit 0 cleared), stall beats jump, jump beats branch.
    step(F_BR,          32'h20, 32'h80, 0,      32'h80,  1, R, 32'h0, 0);
    step(F_JMP,         32'h80, 0,      32'h101, 32'h100, 1, R, 32'h0, 0);
    step(F_STALL|F_JMP, 32'h20, 0,      32'h200, 32'h20,  1, R, 32'h0, 0);
    step(F_BR|F_JMP,    32'h20, 32'h80, 32'h40,  32'h40,  1, R, 32'h0, 0);
    // Trap at 0x44, bubble ignores requests, then mret.
    step(F_TRAP, 32'h44,  0, 0, 32'h100, 1, R, 32'h0,  0);
    step(F_TRAP, 32'h100, 0, 0, 32'h100, 0, T, 32'h44, 0);
    step(8'h0,   32'h100, 0, 0, 32'h104, 1, R, 32'h44, 0);
    step(F_MRET, 32'h104, 0, 0, 32'h44,  1, R, 32'h44, 0);
    // trap + mret together: trap wins and epc is overwritten.
    step(F_TRAP|F_MRET, 32'h48,  0, 0, 32'h100, 1, R, 32'h44, 0);
    step(8'h0,          32'h100, 0, 0, 32'h100, 0, T, 32'h48, 0);
    step(F_MRET,        32'h100, 0, 0, 32'h48,  1, R, 32'h48, 0);
    // Misaligned branch target.
    step(F_BR, 32'h30,  32'h1002, 0, 32'h100, 1, R, 32'h48, 0);
    step(8'h0, 32'h100, 0,        0, 32'h100, 0, T, 32'h30, 1);
    step(8'h0, 32'h100, 0,        0, 32'h104, 1, R, 32'h30, 1);
    // Misaligned jump target after bit-0 clear (0x203 -> 0x202).
    step(F_JMP, 32'h104, 0, 32'h203, 32'h100, 1, R, 32'h30,  1);
    step(8'h0,  32'h100, 0, 0,       32'h100, 0, T, 32'h104, 1);
    // Halt at 0x10 for 5 cycles, trap ignored, then resume.
    step(F_HALT, 32'h10, 0, 0, 32'h10, 1, R, 32'h104, 1);
    for (int i = 0; i < 5; i++) step(F_TRAP, 32'h10, 0, 0, 32'h10, 0, H, 32'h104, 1);
    step(F_RES, 32'h10, 0, 0, 32'h10, 0, H, 32'h104, 1);
    step(8'h0,  32'h10, 0, 0, 32'h14, 1, R, 32'h104, 1);
    // Sequential wrap.
    step(8'h0, 32'hFFFF_FFFC, 0, 0, 32'h0, 1, R, 32'h104, 1);
    // Reset during HALT: back to BOOT, registers cleared, counter restarted.
    step(F_HALT, 32'h20, 0, 0, 32'h20, 1, R, 32'h104, 1);
    step(8'h0,   32'h20, 0, 0, 32'h20, 0, H, 32'h104, 1);
    step(F_RST,  32'h20, 0, 0, 32'h0,  0, B, 32'h104, 1);
    for (int i = 0; i < 4; i++) step(8'h0, 32'h0, 0, 0, 32'h0, 0, B, 32'h0, 0);
    step(8'h0, 32'h0, 0, 0, 32'h4, 1, R, 32'h0, 0);
    stim_done = 1'b1;
  end

  // Drain the scoreboard with a bounded wait, then report.
  initial begin
    int budget;
    budget = 0;
    while (!(stim_done && exp_q.size() == 0) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    @(posedge clk);
    checks++;
    if (!(stim_done && exp_q.size() == 0)) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
